// File: rtl/period_pkg.sv
// Shared definitions for the period measurement block: FSM encoding and counter width rule.
package period_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    ARM     = S_ARM,
    MEASURE = S_MEASURE,
    DONE    = S_DONE
  } state_e;

  // Counter value width for a counter saturating at max_val; the attached counter uses the same rule.
  function automatic int cw_of(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector with an optional 2-flop input synchroniser (macro PERIOD_MEASURE_SYNC_EN).
module edge_detector (
  input  logic clock_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_s;
  logic sig_q;

`ifdef PERIOD_MEASURE_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q;
`else
  assign sig_s = sig_i;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) sig_q <= 1'b0;
    else         sig_q <= sig_s;
  end

  assign rise_o = sig_s & ~sig_q;

endmodule

// File: rtl/period_measure.sv
// Period measurement controller driving an external saturating counter; one result per start request.
// Build option: PERIOD_MEASURE_SYNC_EN inserts a 2-flop synchroniser on signal_i.
// Handshake: a result is transferred on the clock edge where valid_o and ready_i are both high;
// valid_o, result_o and timeout_o stay stable until then.
module period_measure
  import period_pkg::*;
#(
  parameter int  MAX_COUNTER_VALUE = 2000,
  localparam int CW                = cw_of(MAX_COUNTER_VALUE)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          signal_i,
  output logic          counter_reset_o,
  output logic          counter_enable_o,
  input  logic          counter_finished_i,
  input  logic [CW-1:0] counter_val_i,
  output logic [CW-1:0] result_o,
  output logic          timeout_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          busy_o
);

  state_e        state_q, state_d;
  logic          cnt_rst_q, cnt_rst_d;
  logic          cnt_en_q, cnt_en_d;
  logic [CW-1:0] result_q, result_d;
  logic          timeout_q, timeout_d;
  logic          valid_q, valid_d;
  logic          busy_q;
  logic          rise;

  edge_detector u_edge (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .sig_i   (signal_i),
    .rise_o  (rise)
  );

  always_comb begin
    state_d   = state_q;
    cnt_rst_d = cnt_rst_q;
    cnt_en_d  = cnt_en_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        cnt_rst_d = 1'b1;
        cnt_en_d  = 1'b0;
        if (start_i) begin
          state_d   = ARM;
          cnt_rst_d = 1'b0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d  = MEASURE;
          cnt_en_d = 1'b1;
        end
      end
      MEASURE: begin
        // A closing edge takes priority over saturation in the same cycle.
        if (rise || counter_finished_i) begin
          state_d   = DONE;
          result_d  = counter_val_i;
          timeout_d = ~rise;
          cnt_en_d  = 1'b0;
          valid_d   = 1'b1;
        end
      end
      DONE: begin
        if (valid_q && ready_i) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          cnt_rst_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_rst_q <= 1'b1;
      cnt_en_q  <= 1'b0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_en_q  <= cnt_en_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign counter_reset_o  = cnt_rst_q;
  assign counter_enable_o = cnt_en_q;
  assign result_o         = result_q;
  assign timeout_o        = timeout_q;
  assign valid_o          = valid_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_period_measure.sv
// Bench for period_measure: two instances (saturation 2000 and 8), each with a behavioural counter beside it.
module tb_period_measure;

  localparam int MAX_A = 2000;
  localparam int MAX_B = 8;
`ifdef PERIOD_MEASURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, sig_a, ready_a, crst_a, cen_a, cfin_a, to_a, valid_a, busy_a;
  logic [10:0] cnt_a, res_a;
  logic        start_b, sig_b, ready_b, crst_b, cen_b, cfin_b, to_b, valid_b, busy_b;
  logic [3:0]  cnt_b, res_b;

  int n_cmp = 0;
  int n_err = 0;

  period_measure #(.MAX_COUNTER_VALUE(MAX_A)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start_a), .signal_i(sig_a),
    .counter_reset_o(crst_a), .counter_enable_o(cen_a), .counter_finished_i(cfin_a),
    .counter_val_i(cnt_a), .result_o(res_a), .timeout_o(to_a), .valid_o(valid_a),
    .ready_i(ready_a), .busy_o(busy_a)
  );

  period_measure #(.MAX_COUNTER_VALUE(MAX_B)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start_b), .signal_i(sig_b),
    .counter_reset_o(crst_b), .counter_enable_o(cen_b), .counter_finished_i(cfin_b),
    .counter_val_i(cnt_b), .result_o(res_b), .timeout_o(to_b), .valid_o(valid_b),
    .ready_i(ready_b), .busy_o(busy_b)
  );

  // Saturating counters standing in for the real time base.
  always @(posedge clk) begin
    if (rst || crst_a)                     cnt_a <= '0;
    else if (cen_a && cnt_a != 11'(MAX_A)) cnt_a <= cnt_a + 11'd1;
    if (rst || crst_b)                     cnt_b <= '0;
    else if (cen_b && cnt_b != 4'(MAX_B))  cnt_b <= cnt_b + 4'd1;
  end
  assign cfin_a = (cnt_a == 11'(MAX_A));
  assign cfin_b = (cnt_b == 4'(MAX_B));

  typedef struct {
    int w;
    int p;
    int h;
    int exp_r;
    bit exp_t;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v; else start_b = v;
  endtask
  task automatic set_sig(input int w, input logic v);
    if (w == 0) sig_a = v; else sig_b = v;
  endtask
  task automatic set_ready(input int w, input logic v);
    if (w == 0) ready_a = v; else ready_b = v;
  endtask

  function automatic logic get_valid(input int w);
    return (w == 0) ? valid_a : valid_b;
  endfunction
  function automatic logic get_to(input int w);
    return (w == 0) ? to_a : to_b;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_crst(input int w);
    return (w == 0) ? crst_a : crst_b;
  endfunction
  function automatic logic get_cen(input int w);
    return (w == 0) ? cen_a : cen_b;
  endfunction
  function automatic logic [10:0] get_res(input int w);
    return (w == 0) ? res_a : {7'd0, res_b};
  endfunction

  // Reference: a period of P clocks reads as P-1, unless that exceeds the counter ceiling.
  function automatic int model_res(input int p, input int max_v);
    return (p - 1 > max_v) ? max_v : p - 1;
  endfunction
  function automatic bit model_to(input int p, input int max_v);
    return (p - 1 > max_v);
  endfunction

  task automatic wait_valid(input int w, input int budget, output int n);
    n = 0;
    while (!get_valid(w) && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Start, one opening rise, a closing rise p clocks later; result is left pending in DONE.
  task automatic meas(input int w, input int p, input int h, input int exp_r, input bit exp_t,
                      input string tag);
    int n;
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
    chk({tag, " busy_arm"}, get_busy(w), 1);
    repeat (3) tick();
    set_sig(w, 1'b1);
    for (int i = 1; i < p; i++) begin
      tick();
      if (i == h) set_sig(w, 1'b0);
    end
    tick();
    set_sig(w, 1'b1);
    wait_valid(w, 100, n);
    chk({tag, " valid"}, get_valid(w), 1);
    if (!exp_t) chk({tag, " latency"}, n, LAT);
    chk({tag, " result"}, get_res(w), exp_r);
    chk({tag, " timeout"}, get_to(w), exp_t);
  endtask

  task automatic accept(input int w, input int exp_r, input string tag);
    set_sig(w, 1'b0);
    set_ready(w, 1'b1);
    tick();
    set_ready(w, 1'b0);
    chk({tag, " valid_after_hs"}, get_valid(w), 0);
    chk({tag, " busy_after_hs"}, get_busy(w), 0);
    chk({tag, " result_held"}, get_res(w), exp_r);
    chk({tag, " crst_after_hs"}, get_crst(w), 1);
    repeat (4) tick();
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    vecs[0] = '{0, 10, 5, 9, 1'b0};
    vecs[1] = '{0, 2, 1, 1, 1'b0};
    vecs[2] = '{0, 37, 20, 36, 1'b0};
    vecs[3] = '{1, 9, 4, 8, 1'b0};
    vecs[4] = '{1, 10, 5, 8, 1'b1};
    vecs[5] = '{1, 3, 2, 2, 1'b0};
    vecs[6] = '{1, 14, 1, 8, 1'b1};

    rst = 1'b1;
    start_a = 0; sig_a = 0; ready_a = 0;
    start_b = 0; sig_b = 0; ready_b = 0;
    repeat (3) tick();
    for (int w = 0; w < 2; w++) begin
      chk("rst crst", get_crst(w), 1);
      chk("rst cen", get_cen(w), 0);
      chk("rst valid", get_valid(w), 0);
      chk("rst timeout", get_to(w), 0);
      chk("rst result", get_res(w), 0);
      chk("rst busy", get_busy(w), 0);
    end
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      meas(vecs[i].w, vecs[i].p, vecs[i].h, vecs[i].exp_r, vecs[i].exp_t, $sformatf("vec%0d", i));
      accept(vecs[i].w, vecs[i].exp_r, $sformatf("vec%0d", i));
    end

    // Signal stuck low after one rise: saturation at 2000.
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    repeat (3) tick();
    set_sig(0, 1'b1);
    tick();
    set_sig(0, 1'b0);
    wait_valid(0, 2200, n);
    chk("stuck valid", valid_a, 1);
    chk("stuck timeout", to_a, 1);
    chk("stuck result", res_a, MAX_A);
    accept(0, MAX_A, "stuck");

    // Consumer stalls in DONE while start and signal keep moving.
    meas(0, 12, 6, 11, 1'b0, "stall");
    for (int i = 0; i < 20; i++) begin
      set_sig(0, logic'(i % 2));
      set_start(0, logic'($urandom_range(0, 1)));
      tick();
      chk("stall valid", valid_a, 1);
      chk("stall result", res_a, 11);
      chk("stall timeout", to_a, 0);
      chk("stall cen", cen_a, 0);
    end
    set_start(0, 1'b0);
    accept(0, 11, "stall");
    chk("idle stays idle", busy_a, 0);

    // ready without valid does nothing; then reset lands mid-measurement.
    set_ready(0, 1'b1);
    repeat (3) tick();
    set_ready(0, 1'b0);
    chk("ready_no_valid busy", busy_a, 0);
    chk("ready_no_valid valid", valid_a, 0);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    repeat (3) tick();
    set_sig(0, 1'b1);
    repeat (6) tick();
    chk("mid cen", cen_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_sig(0, 1'b0);
    chk("midrst crst", crst_a, 1);
    chk("midrst cen", cen_a, 0);
    chk("midrst valid", valid_a, 0);
    chk("midrst busy", busy_a, 0);
    repeat (4) tick();
    chk("midrst no result", valid_a, 0);
    meas(0, 7, 3, 6, 1'b0, "after_rst");
    accept(0, 6, "after_rst");

`ifndef PERIOD_MEASURE_SYNC_EN
    // A rise coincident with ARM entry is not an opening edge.
    set_start(0, 1'b1);
    set_sig(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    repeat (3) tick();
    set_sig(0, 1'b0);
    repeat (5) tick();
    set_sig(0, 1'b1);
    repeat (2) tick();
    set_sig(0, 1'b0);
    repeat (3) tick();
    set_sig(0, 1'b1);
    wait_valid(0, 100, n);
    chk("arm_entry latency", n, LAT);
    chk("arm_entry result", res_a, 4);
    accept(0, 4, "arm_entry");
`endif

    for (int k = 0; k < 30; k++) begin
      int w, p, h, mx;
      w  = $urandom_range(0, 1);
      p  = (w == 0) ? $urandom_range(2, 60) : $urandom_range(2, 14);
      h  = $urandom_range(1, p - 1);
      mx = (w == 0) ? MAX_A : MAX_B;
      meas(w, p, h, model_res(p, mx), model_to(p, mx), $sformatf("rnd%0d_w%0d_p%0d", k, w, p));
      accept(w, model_res(p, mx), $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
